mem_stage_lsu: RTL and testbench

Memory-stage load/store engine sitting directly downstream of the EX/MEM pipeline register.
- Consumes the held load/store fields (is_load, is_store, ls_size, is_unsigned, ls_address, store data).
- Issues one naturally-aligned doubleword request to the data-memory port and waits for its response.
- Returns aligned, sign- or zero-extended load data as opload_read_data_wb.
- Holds mem_stall high until the access completes, so the EX/MEM register keeps the instruction stable.

---
 rtl/mem_stage_lsu.sv | 165 ++++++++++++++++
 tb/tb_mem_stage_lsu.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store engine: issues one aligned doubleword request per
// EX/MEM load/store, stalls the pipe until it completes, and formats load data.
module mem_stage_lsu #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              op_valid,
  input  logic              is_load,
  input  logic              is_store,
  input  logic              is_unsigned,
  input  logic [3:0]        ls_size,
  input  logic [ADDR_W-1:0] ls_address,
  input  logic [DATA_W-1:0] store_data,
  input  logic              ext_stall,
  input  logic              flush,
  output logic              mem_stall,
  output logic              misalign_err,
  output logic              req_valid,
  input  logic              req_ready,
  output logic              req_write,
  output logic [ADDR_W-1:0] req_addr,
  output logic [DATA_W-1:0] req_wdata,
  output logic [7:0]        req_wmask,
  input  logic              resp_valid,
  input  logic [DATA_W-1:0] resp_rdata,
  output logic [DATA_W-1:0] opload_read_data_wb
);

  localparam int unsigned LANES = DATA_W / 8;
  localparam int unsigned OFF_W = 3;

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_DONE} state_t;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} lsz_t;

  state_t            state;
  state_t            state_next;
  lsz_t              size_c;
  lsz_t              lat_size;
  logic [OFF_W-1:0]  off_c;
  logic [OFF_W-1:0]  lat_off;
  logic              lat_uns;
  logic              flush_pending;
  logic              misaligned_c;
  logic              mem_op_c;
  logic              issue_c;
  logic              bad_c;
  logic              kill_c;
  logic              load_wr_c;
  logic [LANES-1:0]  base_mask_c;
  logic [DATA_W-1:0] shifted_c;
  logic [DATA_W-1:0] load_fmt_c;

  // Size decode; anything that is not one-hot behaves as a doubleword.
  always_comb begin
    size_c = SZ_D;
    case (ls_size)
      4'b0001: size_c = SZ_B;
      4'b0010: size_c = SZ_H;
      4'b0100: size_c = SZ_W;
      default: size_c = SZ_D;
    endcase
  end

  assign off_c = ls_address[OFF_W-1:0];

  // Natural-alignment check and byte-enable pattern before lane shift.
  always_comb begin
    misaligned_c = 1'b0;
    base_mask_c  = LANES'(8'hFF);
    case (size_c)
      SZ_B: begin misaligned_c = 1'b0;         base_mask_c = LANES'(8'h01); end
      SZ_H: begin misaligned_c = off_c[0];     base_mask_c = LANES'(8'h03); end
      SZ_W: begin misaligned_c = |off_c[1:0];  base_mask_c = LANES'(8'h0F); end
      SZ_D: begin misaligned_c = |off_c;       base_mask_c = LANES'(8'hFF); end
      default: begin misaligned_c = |off_c;    base_mask_c = LANES'(8'hFF); end
    endcase
  end

  assign mem_op_c  = reset_n & op_valid & (is_load | is_store) & ~flush;
  assign issue_c   = (state == ST_IDLE) & mem_op_c & ~misaligned_c;
  assign bad_c     = (state == ST_IDLE) & mem_op_c & misaligned_c;
  assign kill_c    = flush_pending | flush;
  assign load_wr_c = (state == ST_WAIT) & resp_valid & ~req_write & ~kill_c;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (issue_c) state_next = ST_REQ;
      ST_REQ:  if (req_ready) state_next = ST_WAIT;
      ST_WAIT: if (resp_valid) state_next = kill_c ? ST_IDLE : ST_DONE;
      ST_DONE: if (flush || !ext_stall) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // IDLE stall is combinational so the EX/MEM register freezes on the issue cycle.
  always_comb begin
    mem_stall = 1'b0;
    req_valid = 1'b0;
    case (state)
      ST_IDLE: mem_stall = issue_c;
      ST_REQ:  begin mem_stall = 1'b1; req_valid = 1'b1; end
      ST_WAIT: mem_stall = 1'b1;
      ST_DONE: mem_stall = 1'b0;
      default: mem_stall = 1'b0;
    endcase
  end

  // Request fields are captured once at issue and held until the next issue.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      req_addr  <= '0;
      req_wdata <= '0;
      req_wmask <= '0;
      req_write <= 1'b0;
      lat_size  <= SZ_D;
      lat_off   <= '0;
      lat_uns   <= 1'b0;
    end else if (issue_c) begin
      req_addr  <= {ls_address[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
      req_wdata <= store_data << {off_c, 3'b000};
      req_wmask <= base_mask_c << off_c;
      req_write <= is_store;
      lat_size  <= size_c;
      lat_off   <= off_c;
      lat_uns   <= is_unsigned;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                                     flush_pending <= 1'b0;
    else if (state_next == ST_IDLE || issue_c)        flush_pending <= 1'b0;
    else if (flush && (state == ST_REQ || state == ST_WAIT)) flush_pending <= 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) misalign_err <= 1'b0;
    else          misalign_err <= bad_c;
  end

  // Lane-align the returned doubleword and extend to the access size.
  always_comb begin
    shifted_c  = resp_rdata >> {lat_off, 3'b000};
    load_fmt_c = shifted_c;
    case (lat_size)
      SZ_B: load_fmt_c = {{(DATA_W-8){~lat_uns & shifted_c[7]}},   shifted_c[7:0]};
      SZ_H: load_fmt_c = {{(DATA_W-16){~lat_uns & shifted_c[15]}}, shifted_c[15:0]};
      SZ_W: load_fmt_c = {{(DATA_W-32){~lat_uns & shifted_c[31]}}, shifted_c[31:0]};
      default: load_fmt_c = shifted_c;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)       opload_read_data_wb <= '0;
    else if (load_wr_c) opload_read_data_wb <= load_fmt_c;
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu: directed scenarios plus randomized
// loads/stores checked against a byte-array memory model.
module tb_mem_stage_lsu;

  logic        clock;
  logic        reset_n;
  logic        op_valid;
  logic        is_load;
  logic        is_store;
  logic        is_unsigned;
  logic [3:0]  ls_size;
  logic [63:0] ls_address;
  logic [63:0] store_data;
  logic        ext_stall;
  logic        flush;
  logic        mem_stall;
  logic        misalign_err;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [7:0]  req_wmask;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic [63:0] opload_read_data_wb;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_accept = 0;
  logic [7:0]  mem [256];
  logic [63:0] last_load;

  mem_stage_lsu #(.ADDR_W(64), .DATA_W(64)) dut (
    .clock(clock), .reset_n(reset_n), .op_valid(op_valid), .is_load(is_load),
    .is_store(is_store), .is_unsigned(is_unsigned), .ls_size(ls_size),
    .ls_address(ls_address), .store_data(store_data), .ext_stall(ext_stall),
    .flush(flush), .mem_stall(mem_stall), .misalign_err(misalign_err),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .opload_read_data_wb(opload_read_data_wb)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) if (reset_n && req_valid && req_ready) n_accept <= n_accept + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  function automatic int size_bytes(input logic [3:0] sz);
    case (sz)
      4'b0001: return 1;
      4'b0010: return 2;
      4'b0100: return 4;
      default: return 8;
    endcase
  endfunction

  task automatic idle_inputs();
    op_valid = 1'b0; is_load = 1'b0; is_store = 1'b0; is_unsigned = 1'b0;
    ls_size = 4'b0000; ls_address = '0; store_data = '0;
  endtask

  // One complete memory op with the bench acting as the memory port.
  task automatic run_op(input logic ld, input logic st, input logic uns, input logic [3:0] sz,
                        input logic [63:0] addr, input logic [63:0] sdata,
                        input int rdy_dly, input int resp_dly, input int ext_cyc, input bit do_flush);
    int nb, off, phase, reqv, waitc, stallc, k;
    logic [63:0] e_addr, e_wdata, e_rdword, e_load, raw;
    logic [7:0]  e_mask, idx;
    nb = size_bytes(sz);
    off = int'(addr[2:0]);
    e_addr = addr & ~64'h7;
    e_wdata = '0; e_mask = '0; e_rdword = '0; raw = '0;
    for (int i = 0; i < 8; i++) begin
      if (i >= off) e_wdata[i*8 +: 8] = sdata[(i-off)*8 +: 8];
      if (i >= off && i < off + nb) e_mask[i] = 1'b1;
      idx = e_addr[7:0] + 8'(i);
      e_rdword[i*8 +: 8] = mem[idx];
    end
    for (int i = 0; i < nb; i++) begin
      idx = addr[7:0] + 8'(i);
      raw[i*8 +: 8] = mem[idx];
    end
    if (!uns && nb < 8 && raw[nb*8-1]) raw = raw | ~((64'd1 << (nb*8)) - 64'd1);
    e_load = (st || do_flush) ? last_load : raw;

    @(posedge clock); #1;
    op_valid = 1'b1; is_load = ld; is_store = st; is_unsigned = uns;
    ls_size = sz; ls_address = addr; store_data = sdata;
    phase = 0; reqv = 0; waitc = 0; stallc = 0; k = 0;
    for (int cyc = 0; cyc < 100 && phase < 3; cyc++) begin
      @(negedge clock);
      req_ready = 1'b0; resp_valid = 1'b0; flush = 1'b0; ext_stall = 1'b0;
      if (mem_stall) stallc++;
      if (phase == 0) begin
        if (req_valid) begin
          reqv++;
          if (reqv == 1) check1("no_misalign", misalign_err, 1'b0);
          check("req_addr", req_addr, e_addr);
          check("req_wmask", 64'(req_wmask), 64'(e_mask));
          check1("req_write", req_write, st);
          if (st) check("req_wdata", req_wdata, e_wdata);
          if (reqv > rdy_dly) begin req_ready = 1'b1; phase = 1; end
        end
      end else if (phase == 1) begin
        waitc++;
        check1("req_dropped", req_valid, 1'b0);
        if (do_flush && waitc == 1) begin flush = 1'b1; op_valid = 1'b0; end
        if (waitc >= resp_dly) begin
          resp_valid = 1'b1; resp_rdata = e_rdword; phase = 2;
        end
      end else begin
        check1("done_stall", mem_stall, 1'b0);
        check1("done_no_req", req_valid, 1'b0);
        check("load_data", opload_read_data_wb, e_load);
        if (k < ext_cyc) ext_stall = 1'b1;
        else phase = 3;
        k++;
      end
    end
    check("op_complete", 64'(phase), 64'd3);
    check("stall_cycles", 64'(stallc), 64'(2 + rdy_dly + resp_dly));
    @(posedge clock); #1;
    idle_inputs();
    ext_stall = 1'b0;
    if (st) begin
      for (int i = 0; i < 8; i++) if (e_mask[i]) begin
        idx = e_addr[7:0] + 8'(i);
        mem[idx] = e_wdata[i*8 +: 8];
      end
    end else if (!do_flush) last_load = e_load;
  endtask

  task automatic misalign_op(input string tag, input logic [3:0] sz, input logic [63:0] addr);
    int acc0;
    acc0 = n_accept;
    @(posedge clock); #1;
    op_valid = 1'b1; is_load = 1'b1; ls_size = sz; ls_address = addr;
    @(negedge clock);
    check1({tag, "_stall"}, mem_stall, 1'b0);
    check1({tag, "_err_early"}, misalign_err, 1'b0);
    @(posedge clock); #1;
    idle_inputs();
    @(negedge clock);
    check1({tag, "_err_pulse"}, misalign_err, 1'b1);
    check1({tag, "_no_req"}, req_valid, 1'b0);
    @(negedge clock);
    check1({tag, "_err_end"}, misalign_err, 1'b0);
    check({tag, "_accepts"}, 64'(n_accept), 64'(acc0));
  endtask

  initial begin
    int acc0;
    bit got;
    logic [3:0]  sz;
    logic [63:0] a;
    int nb;
    reset_n = 1'b0;
    idle_inputs();
    ext_stall = 1'b0; flush = 1'b0; req_ready = 1'b0; resp_valid = 1'b0; resp_rdata = '0;
    last_load = '0;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    repeat (3) @(negedge clock);
    check1("rst_stall", mem_stall, 1'b0);
    check1("rst_req_valid", req_valid, 1'b0);
    check("rst_load", opload_read_data_wb, 64'd0);
    reset_n = 1'b1;

    // Doubleword at 0x1000 holds 0x80 in byte 3.
    for (int i = 0; i < 8; i++) mem[i] = 8'h00;
    mem[3] = 8'h80;
    run_op(1'b1, 1'b0, 1'b0, 4'b0001, 64'h1003, 64'd0, 0, 1, 0, 1'b0);
    check("lb_signed", last_load, 64'hFFFF_FFFF_FFFF_FF80);
    run_op(1'b1, 1'b0, 1'b1, 4'b0001, 64'h1003, 64'd0, 0, 1, 0, 1'b0);
    check("lb_unsigned", last_load, 64'h80);

    run_op(1'b0, 1'b1, 1'b0, 4'b0010, 64'h2006, 64'hABCD, 0, 1, 0, 1'b0);
    check("sh_keeps_load", opload_read_data_wb, 64'h80);

    mem[4] = 8'h10; mem[5] = 8'h32; mem[6] = 8'h54; mem[7] = 8'h76;
    run_op(1'b1, 1'b0, 1'b0, 4'b0100, 64'h3004, 64'd0, 3, 2, 0, 1'b0);
    check("lw_result", last_load, 64'h7654_3210);

    misalign_op("ld_mis", 4'b1000, 64'h4004);
    misalign_op("lh_mis", 4'b0010, 64'h2001);
    misalign_op("lw_mis", 4'b0100, 64'h3002);

    run_op(1'b1, 1'b0, 1'b1, 4'b0110, 64'h6010, 64'd0, 1, 1, 0, 1'b0);

    acc0 = n_accept;
    run_op(1'b1, 1'b0, 1'b0, 4'b1000, 64'h4008, 64'd0, 0, 1, 2, 1'b0);
    check("ext_one_request", 64'(n_accept - acc0), 64'd1);

    run_op(1'b1, 1'b0, 1'b0, 4'b0100, 64'h3004, 64'd0, 0, 2, 0, 1'b1);
    @(negedge clock);
    check1("flush_idle", mem_stall, 1'b0);

    // Reset in the middle of a load, then a stray response.
    @(posedge clock); #1;
    op_valid = 1'b1; is_load = 1'b1; ls_size = 4'b1000; ls_address = 64'h5000;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clock);
      if (req_valid) begin req_ready = 1'b1; got = 1'b1; end
    end
    check1("rst_req_seen", got, 1'b1);
    @(negedge clock);
    req_ready = 1'b0;
    check1("wait_stall", mem_stall, 1'b1);
    reset_n = 1'b0;
    idle_inputs();
    #1;
    check1("rst_mid_stall", mem_stall, 1'b0);
    check1("rst_mid_err", misalign_err, 1'b0);
    check1("rst_mid_valid", req_valid, 1'b0);
    check1("rst_mid_write", req_write, 1'b0);
    check("rst_mid_addr", req_addr, 64'd0);
    check("rst_mid_wdata", req_wdata, 64'd0);
    check("rst_mid_wmask", 64'(req_wmask), 64'd0);
    check("rst_mid_load", opload_read_data_wb, 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    resp_valid = 1'b1; resp_rdata = 64'hDEAD_BEEF_CAFE_F00D;
    @(negedge clock);
    resp_valid = 1'b0;
    check("late_resp_ignored", opload_read_data_wb, 64'd0);
    check1("late_resp_stall", mem_stall, 1'b0);
    check1("late_resp_req", req_valid, 1'b0);
    last_load = '0;

    for (int t = 0; t < 40; t++) begin
      case ($urandom_range(0, 3))
        0: sz = 4'b0001;
        1: sz = 4'b0010;
        2: sz = 4'b0100;
        default: sz = 4'b1000;
      endcase
      nb = size_bytes(sz);
      a = {32'($urandom), 32'($urandom)};
      a[2:0] = 3'($urandom_range(0, 7)) & ~3'(nb - 1);
      if ($urandom_range(0, 1) == 1)
        run_op(1'b0, 1'b1, 1'b0, sz, a, {32'($urandom), 32'($urandom)},
               $urandom_range(0, 2), $urandom_range(1, 3), $urandom_range(0, 2), 1'b0);
      else
        run_op(1'b1, 1'b0, 1'($urandom_range(0, 1)), sz, a, 64'd0,
               $urandom_range(0, 2), $urandom_range(1, 3), $urandom_range(0, 2), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
